// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: key-driven BCD operand entry, operator latch and ALU start/done sequencing.
// Optional backspace editing is compiled in when CALC_BKSP_EN is defined.
module calc_entry_ctrl #(
   parameter int unsigned NDIG    = 4,
   parameter int unsigned RW      = 32,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   input  logic [4:0]          key_code,
   input  logic                alu_busy,
   input  logic                alu_done,
   input  logic                alu_err,
   input  logic [RW-1:0]       alu_result,
   output logic [4*NDIG-1:0]   op_a,
   output logic [4*NDIG-1:0]   op_b,
   output logic [1:0]          alu_op,
   output logic                alu_start,
   output logic [RW-1:0]       result,
   output logic [1:0]          disp_sel,
   output logic                err
);

   localparam int unsigned OW = 4 * NDIG;
   localparam int unsigned CW = $clog2(NDIG + 1);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_EXEC    = 3'd2,
      S_WAIT    = 3'd3,
      S_SHOW    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   state_t         state, state_d;
   logic [CW-1:0]  cnt_a, cnt_a_d;
   logic [CW-1:0]  cnt_b, cnt_b_d;
   logic [TW-1:0]  tmo, tmo_d;
   logic [OW-1:0]  op_a_d, op_b_d;
   logic [1:0]     alu_op_d, disp_sel_d;
   logic           alu_start_d, err_d;
   logic [RW-1:0]  result_d;

   logic           is_digit, is_oper, is_enter, is_clear, is_bksp;
   logic [3:0]     digit;
   logic [1:0]     oper;

   // Key classification; only one key class can be active per strobe.
   always_comb begin
      is_digit = key_valid && (key_code <= 5'd9);
      is_oper  = key_valid && (key_code >= 5'd10) && (key_code <= 5'd13);
      is_enter = key_valid && (key_code == 5'd14);
      is_clear = key_valid && (key_code == 5'd15);
`ifdef CALC_BKSP_EN
      is_bksp  = key_valid && (key_code == 5'd16);
`else
      is_bksp  = 1'b0;
`endif
      digit    = key_code[3:0];
      oper     = 2'(key_code - 5'd10);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state;
      op_a_d      = op_a;
      op_b_d      = op_b;
      cnt_a_d     = cnt_a;
      cnt_b_d     = cnt_b;
      alu_op_d    = alu_op;
      result_d    = result;
      tmo_d       = tmo;
      alu_start_d = 1'b0;
      disp_sel_d  = 2'd0;
      err_d       = 1'b0;

      if (is_clear) begin
         state_d  = S_ENTER_A;
         op_a_d   = '0;
         op_b_d   = '0;
         cnt_a_d  = '0;
         cnt_b_d  = '0;
         alu_op_d = 2'd0;
      end else begin
         case (state)
            S_ENTER_A: begin
               if (is_digit && (cnt_a != CW'(NDIG))) begin
                  op_a_d  = (op_a << 4) | OW'(digit);
                  cnt_a_d = cnt_a + CW'(1);
               end else if (is_oper && (cnt_a != '0)) begin
                  alu_op_d = oper;
                  state_d  = S_ENTER_B;
               end else if (is_bksp && (cnt_a != '0)) begin
                  op_a_d  = op_a >> 4;
                  cnt_a_d = cnt_a - CW'(1);
               end
            end
            S_ENTER_B: begin
               if (is_digit && (cnt_b != CW'(NDIG))) begin
                  op_b_d  = (op_b << 4) | OW'(digit);
                  cnt_b_d = cnt_b + CW'(1);
               end else if (is_oper && (cnt_b == '0)) begin
                  alu_op_d = oper;
               end else if (is_enter && (cnt_b != '0)) begin
                  state_d = S_EXEC;
               end else if (is_bksp) begin
                  // Backspace past an empty B undoes the operator.
                  if (cnt_b != '0) begin
                     op_b_d  = op_b >> 4;
                     cnt_b_d = cnt_b - CW'(1);
                  end else begin
                     alu_op_d = 2'd0;
                     state_d  = S_ENTER_A;
                  end
               end
            end
            S_EXEC: begin
               if (!alu_busy) begin
                  alu_start_d = 1'b1;
                  tmo_d       = '0;
                  state_d     = S_WAIT;
               end
            end
            S_WAIT: begin
               if (alu_done) begin
                  result_d = alu_result;
                  state_d  = alu_err ? S_ERR : S_SHOW;
               end else if (tmo == TW'(TIMEOUT - 1)) begin
                  state_d = S_ERR;
               end else begin
                  tmo_d = tmo + TW'(1);
               end
            end
            S_SHOW: begin
               if (is_digit) begin
                  op_a_d  = OW'(digit);
                  op_b_d  = '0;
                  cnt_a_d = CW'(1);
                  cnt_b_d = '0;
                  state_d = S_ENTER_A;
               end
            end
            S_ERR: begin
               state_d = S_ERR;
            end
            default: begin
               state_d = S_ENTER_A;
            end
         endcase
      end

      // Display source follows the state being entered.
      case (state_d)
         S_ENTER_A: disp_sel_d = 2'd0;
         S_ENTER_B: disp_sel_d = (cnt_b_d == '0) ? 2'd0 : 2'd1;
         S_EXEC:    disp_sel_d = 2'd1;
         S_WAIT:    disp_sel_d = 2'd1;
         S_SHOW:    disp_sel_d = 2'd2;
         S_ERR:     disp_sel_d = 2'd3;
         default:   disp_sel_d = 2'd0;
      endcase
      err_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_ENTER_A;
         op_a      <= '0;
         op_b      <= '0;
         cnt_a     <= '0;
         cnt_b     <= '0;
         alu_op    <= 2'd0;
         result    <= '0;
         tmo       <= '0;
         alu_start <= 1'b0;
         disp_sel  <= 2'd0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         op_a      <= op_a_d;
         op_b      <= op_b_d;
         cnt_a     <= cnt_a_d;
         cnt_b     <= cnt_b_d;
         alu_op    <= alu_op_d;
         result    <= result_d;
         tmo       <= tmo_d;
         alu_start <= alu_start_d;
         disp_sel  <= disp_sel_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios plus random keys/ALU traffic
// compared every cycle against a digit-queue reference model.
module tb_calc_entry_ctrl;

   localparam int NDIG    = 4;
   localparam int RW      = 32;
   localparam int TIMEOUT = 16;
`ifdef CALC_BKSP_EN
   localparam bit BKSP = 1'b1;
`else
   localparam bit BKSP = 1'b0;
`endif

   localparam int M_A = 0, M_B = 1, M_EXEC = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              key_valid;
   logic [4:0]        key_code;
   logic              alu_busy;
   logic              alu_done;
   logic              alu_err;
   logic [RW-1:0]     alu_result;
   logic [4*NDIG-1:0] op_a;
   logic [4*NDIG-1:0] op_b;
   logic [1:0]        alu_op;
   logic              alu_start;
   logic [RW-1:0]     result;
   logic [1:0]        disp_sel;
   logic              err;

   always #5 clk = ~clk;

   calc_entry_ctrl #(.NDIG(NDIG), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .alu_busy(alu_busy), .alu_done(alu_done), .alu_err(alu_err),
      .alu_result(alu_result), .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
      .alu_start(alu_start), .result(result), .disp_sel(disp_sel), .err(err)
   );

   int          checks = 0;
   int          errors = 0;
   int          m_state, m_op, m_wait;
   bit          m_start;
   logic [31:0] m_result;
   int          qa[$];
   int          qb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = M_A; m_op = 0; m_wait = 0; m_start = 0; m_result = 0;
      qa.delete(); qb.delete();
   endtask

   // Operand value: oldest digit typed is the most significant.
   function automatic logic [31:0] pack(input bit sel_b);
      logic [31:0] v = 0;
      if (sel_b) foreach (qb[i]) v = (v << 4) | 32'(qb[i]);
      else       foreach (qa[i]) v = (v << 4) | 32'(qa[i]);
      return v;
   endfunction

   function automatic logic [31:0] exp_disp();
      case (m_state)
         M_A:            return 0;
         M_B:            return (qb.size() == 0) ? 0 : 1;
         M_EXEC, M_WAIT: return 1;
         M_SHOW:         return 2;
         default:        return 3;
      endcase
   endfunction

   task automatic model_step(input bit kv, input int c, input bit busy, input bit dn,
                             input bit ae, input logic [31:0] res);
      m_start = 0;
      if (kv && c == 15) begin
         qa.delete(); qb.delete(); m_op = 0; m_state = M_A;
      end else begin
         case (m_state)
            M_A: if (kv) begin
               if (c <= 9) begin
                  if (qa.size() < NDIG) qa.push_back(c);
               end else if (c >= 10 && c <= 13) begin
                  if (qa.size() > 0) begin m_op = c - 10; m_state = M_B; end
               end else if (c == 16 && BKSP && qa.size() > 0) begin
                  void'(qa.pop_back());
               end
            end
            M_B: if (kv) begin
               if (c <= 9) begin
                  if (qb.size() < NDIG) qb.push_back(c);
               end else if (c >= 10 && c <= 13) begin
                  if (qb.size() == 0) m_op = c - 10;
               end else if (c == 14) begin
                  if (qb.size() > 0) m_state = M_EXEC;
               end else if (c == 16 && BKSP) begin
                  if (qb.size() > 0) void'(qb.pop_back());
                  else begin m_op = 0; m_state = M_A; end
               end
            end
            M_EXEC: if (!busy) begin
               m_start = 1; m_wait = 0; m_state = M_WAIT;
            end
            M_WAIT: begin
               if (dn) begin
                  m_result = res;
                  m_state  = ae ? M_ERR : M_SHOW;
               end else begin
                  m_wait++;
                  if (m_wait == TIMEOUT) m_state = M_ERR;
               end
            end
            M_SHOW: if (kv && c <= 9) begin
               qa.delete(); qb.delete(); qa.push_back(c); m_state = M_A;
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".op_a"},      op_a,      pack(1'b0));
      check({tag, ".op_b"},      op_b,      pack(1'b1));
      check({tag, ".alu_op"},    alu_op,    32'(m_op));
      check({tag, ".alu_start"}, alu_start, 32'(m_start));
      check({tag, ".result"},    result,    m_result);
      check({tag, ".disp_sel"},  disp_sel,  exp_disp());
      check({tag, ".err"},       err,       32'(m_state == M_ERR));
   endtask

   task automatic step(input bit kv, input int c, input bit busy, input bit dn,
                       input bit ae, input logic [31:0] res);
      key_valid = kv; key_code = 5'(c); alu_busy = busy;
      alu_done = dn; alu_err = ae; alu_result = res;
      @(posedge clk);
      model_step(kv, c, busy, dn, ae, res);
      #1;
      compare_all("cyc");
      key_valid = 1'b0; alu_done = 1'b0;
   endtask

   task automatic key(input int c);
      step(1'b1, c, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic idle(input bit busy);
      step(1'b0, 0, busy, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_code = '0; alu_busy = 1'b0;
      alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
      model_reset();
      #2;
      compare_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic add: 12 + 34
      key(1); key(2); key(10); key(3); key(4); key(14);
      idle(1'b0);
      check("t1.start", alu_start, 1);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0, 32'd46);
      check("t1.op_a", op_a, 32'h0012);
      check("t1.op_b", op_b, 32'h0034);
      check("t1.result", result, 32'd46);
      check("t1.disp", disp_sel, 2);
      check("t1.start_once", alu_start, 0);

      // Digit overflow, operator replace, ENTER with empty B
      key(15);
      key(1); key(2); key(3); key(4); key(5);
      check("t2.op_a", op_a, 32'h1234);
      key(13); key(14); idle(1'b0);
      check("t2.alu_op", alu_op, 3);
      check("t2.no_start", alu_start, 0);

      // Busy ALU, error completion, ERR lock, CLEAR
      key(9); key(14);
      for (int i = 0; i < 5; i++) idle(1'b1);
      check("t3.held", alu_start, 0);
      idle(1'b0);
      check("t3.start", alu_start, 1);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1, 32'd77);
      check("t3.err", err, 1);
      check("t3.disp", disp_sel, 3);
      key(4);
      check("t3.err_hold", err, 1);
      key(15);
      check("t3.clr_op_a", op_a, 0);

      // Timeout
      key(1); key(10); key(2); key(14); idle(1'b0);
      for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b0);
      check("t4.not_yet", err, 0);
      idle(1'b0);
      check("t4.timeout", err, 1);
      key(15);

      // CLEAR beats done; late done ignored; async reset mid-WAIT
      key(5); key(10); key(5); key(14); idle(1'b0);
      step(1'b1, 15, 1'b0, 1'b1, 1'b0, 32'd999);
      check("t5.result_kept", result, 32'd77);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0, 32'd555);
      check("t5.late_done", result, 32'd77);
      key(5); key(10); key(5); key(14); idle(1'b0); idle(1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      @(posedge clk); #1;
      compare_all("rst_hold");
      rst = 1'b0;

      // Backspace behaviour (or its absence)
      key(1); key(2); key(3); key(16);
      check("t6.op_a", op_a, BKSP ? 32'h0012 : 32'h0123);
      key(10); key(16); key(7);
      if (BKSP) check("t6.back_a", op_a, 32'h0127);
      else      check("t6.in_b", op_b, 32'h0007);
      key(15);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         bit kv, busy, dn, ae;
         int c;
         kv   = ($urandom_range(0, 2) == 0);
         c    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9))
                                            : int'($urandom_range(10, 31));
         busy = ($urandom_range(0, 3) == 0);
         dn   = (m_state == M_WAIT) ? ($urandom_range(0, 9) == 0)
                                    : ($urandom_range(0, 31) == 0);
         ae   = ($urandom_range(0, 3) == 0);
         step(kv, c, busy, dn, ae, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
